zap_wb_ram: RTL and testbench

Wishbone B3 slave memory that sits directly downstream of the processor's external Wishbone master. It accepts the master's classic single cycles and linear incrementing bursts, the ones the cache line fills and write-backs issue. It serves them from an on-chip word-organised RAM with a programmable number of wait states. It is the default boot/working memory for simulation and FPGA builds.

---
 rtl/zap_wb_pkg.sv | 16 +
 rtl/zap_ram_simple_ben.sv | 22 ++
 rtl/zap_wb_ram.sv | 114 +++++++++++
 tb/tb_zap_wb_ram.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_wb_pkg.sv
// Shared Wishbone definitions for the zap external bus slaves.
package zap_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BEAT,
    BURST
  } wb_state_t;

endpackage

// File: rtl/zap_ram_simple_ben.sv
// Single-port synchronous RAM, registered read, per-byte write enables.
module zap_ram_simple_ben #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WIDTH/8-1:0]       i_ben,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    for (int unsigned b = 0; b < WIDTH/8; b++) begin
      if (i_ben[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    o_rdata <= mem[i_addr];
  end

endmodule

// File: rtl/zap_wb_ram.sv
// Wishbone B3 slave RAM with programmable wait states and linear bursts.
module zap_wb_ram
  import zap_wb_pkg::*;
#(
  parameter int unsigned DEPTH       = 32'd16384,
  parameter int unsigned WAIT_STATES = 32'd1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic [31:0] i_wb_adr,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic [2:0]  i_wb_cti,
  input  logic [1:0]  i_wb_bte,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_dat
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  wb_state_t     state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [AW-1:0] idx, idx_nx, ram_addr, adr_idx;
  logic          ack_nx, req;
  logic [31:0]   dat_nx, ram_q;
  logic [3:0]    ram_ben;
  logic          unused_bits;

  assign adr_idx     = i_wb_adr[AW+1:2];
  assign req         = i_wb_cyc & i_wb_stb;
  // Burst type is always treated as linear; upper address bits alias.
  assign unused_bits = ^{i_wb_bte, i_wb_adr[31:AW+2], i_wb_adr[1:0]};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    ack_nx   = 1'b0;
    dat_nx   = o_wb_dat;
    ram_addr = idx;
    ram_ben  = '0;
    case (state)
      IDLE: begin
        ram_addr = adr_idx;
        if (req) begin
          idx_nx   = adr_idx;
          cnt_nx   = WS;
          state_nx = (WS != 4'd0) ? WAIT : BEAT;
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (!i_wb_cyc)        state_nx = IDLE;
        else if (cnt == 4'd1) state_nx = BEAT;
      end
      BEAT: begin
        ram_addr = idx + AW'(1);
        if (!i_wb_cyc) begin
          state_nx = IDLE;
        end else begin
          ack_nx   = 1'b1;
          dat_nx   = ram_q;
          state_nx = BURST;
        end
      end
      BURST: begin
        // o_wb_dat already holds beat idx and ram_q holds idx+1, so the
        // read issued here is two words ahead to keep one beat per cycle.
        ram_addr = i_wb_we ? idx : idx + AW'(2);
        if (o_wb_ack && req && i_wb_we) ram_ben = i_wb_sel;
        if (req && i_wb_cti == CTI_INCR) begin
          idx_nx = idx + AW'(1);
          ack_nx = 1'b1;
          dat_nx = ram_q;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      o_wb_ack <= 1'b0;
      o_wb_dat <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      o_wb_ack <= ack_nx;
      o_wb_dat <= dat_nx;
    end
  end

  zap_ram_simple_ben #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_ram (
    .i_clk   (i_clk),
    .i_addr  (ram_addr),
    .i_ben   (ram_ben),
    .i_wdata (i_wb_dat),
    .o_rdata (ram_q)
  );

endmodule

// File: tb/tb_zap_wb_ram.sv
// Self-checking bench for zap_wb_ram: vector table, corner sequences, random traffic.
module tb_zap_wb_ram;
  import zap_wb_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WS    = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr, dat, rdat;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  always #5 clk = ~clk;

  zap_wb_ram #(
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_wb_cyc  (cyc),
    .i_wb_stb  (stb),
    .i_wb_adr  (adr),
    .i_wb_we   (we),
    .i_wb_dat  (dat),
    .i_wb_sel  (sel),
    .i_wb_cti  (cti),
    .i_wb_bte  (bte),
    .o_wb_ack  (ack),
    .o_wb_dat  (rdat)
  );

  logic [31:0] model [DEPTH];
  logic [31:0] wbuf  [16];
  logic [31:0] rbuf  [16];
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t tv [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0;
    dat = '0;   sel = '0;   cti = CTI_CLASSIC; bte = BTE_LINEAR;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      tick;
      lat++;
    end while (!ack && lat < 40);
  endtask

  // n beats from byte address a; n == 1 is a classic cycle using cls_cti.
  task automatic access(input bit w, input logic [31:0] a, input int unsigned n,
                        input logic [3:0] s, input logic [2:0] cls_cti, input string tag);
    int          lat;
    int unsigned wi;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s;
    bte = 2'($urandom_range(0, 3));
    cti = (n > 1) ? CTI_INCR : cls_cti;
    dat = wbuf[0];
    wait_ack(lat);
    check({tag, " first-ack latency"}, 32'(lat), 32'(WS + 2));
    for (int unsigned k = 0; k < n; k++) begin
      wi = ((a >> 2) + k) % DEPTH;
      check({tag, " ack"}, {31'b0, ack}, 32'd1);
      rbuf[k] = rdat;
      if (w) model[wi] = merge(model[wi], wbuf[k], s);
      else   check({tag, " rdata"}, rdat, model[wi]);
      tick;
      if (k + 1 < n) begin
        dat = wbuf[k+1];
        cti = (k + 2 == n) ? CTI_EOB : CTI_INCR;
        adr = a + 32'(4 * (k + 1));
      end
    end
    check({tag, " ack low after last beat"}, {31'b0, ack}, 32'd0);
    bus_idle;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    access(1'b0, a, 1, 4'hF, CTI_CLASSIC, "rd");
    d = rbuf[0];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] d;
    logic [2:0]  c;
    int unsigned n;

    // Reset held with an active write request on the bus.
    rst_n = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = '0; dat = '1; sel = 4'hF;
    cti = CTI_CLASSIC; bte = BTE_LINEAR;
    repeat (4) begin
      tick;
      check("reset ack", {31'b0, ack}, 32'd0);
      check("reset dat", rdat, 32'd0);
    end
    bus_idle;
    rst_n = 1'b1;
    tick;

    for (int k = 0; k < 16; k++) wbuf[k] = 32'h10 + 32'(k);
    access(1'b1, 32'h0, 16, 4'hF, CTI_CLASSIC, "init burst");

    access(1'b0, 32'h40, 16, 4'hF, CTI_CLASSIC, "burst16 read");
    for (int k = 0; k < 16; k++) check("burst16 word", rbuf[k], 32'h10 + 32'(k));

    tv[0] = '{1'b1, 32'h100,  32'hDEADBEEF, 4'hF, 32'h0};
    tv[1] = '{1'b0, 32'h100,  32'h0,        4'hF, 32'hDEADBEEF};
    tv[2] = '{1'b1, 32'h00C,  32'h11223344, 4'hF, 32'h0};
    tv[3] = '{1'b1, 32'h00C,  32'hAABBCCDD, 4'h5, 32'h0};
    tv[4] = '{1'b0, 32'h00C,  32'h0,        4'hF, 32'h11BB33DD};
    tv[5] = '{1'b1, 32'h044,  32'h00000000, 4'hF, 32'h0};
    tv[6] = '{1'b1, 32'h044,  32'hCAFEF00D, 4'h8, 32'h0};
    tv[7] = '{1'b0, 32'h1004, 32'h0,        4'hF, 32'hCA000000};
    tv[8] = '{1'b0, 32'h400,  32'h0,        4'hF, 32'hDEADBEEF};
    for (int i = 0; i < 9; i++) begin
      wbuf[0] = tv[i].wdat;
      access(tv[i].we, tv[i].adr, 1, tv[i].sel, CTI_CLASSIC, "table");
      if (!tv[i].we) check("table rdata", rbuf[0], tv[i].exp);
    end

    // Reset asserted while a write to word 0 is being acked.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = '0; dat = '1; sel = 4'hF;
    repeat (3) tick;
    check("pre-reset ack", {31'b0, ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset ack", {31'b0, ack}, 32'd0);
    check("async reset dat", rdat, 32'd0);
    repeat (3) begin
      tick;
      check("held reset ack", {31'b0, ack}, 32'd0);
    end
    bus_idle;
    rst_n = 1'b1;
    tick;
    rd(32'h0, d);
    check("reset no write", d, 32'hDEADBEEF);

    for (int k = 0; k < 4; k++) wbuf[k] = 32'hA000_0000 + 32'(k);
    access(1'b1, 32'(14 * 4), 4, 4'hF, CTI_CLASSIC, "wrap write");
    rd(32'(14 * 4), d); check("wrap w14", d, 32'hA0000000);
    rd(32'(15 * 4), d); check("wrap w15", d, 32'hA0000001);
    rd(32'h0, d);       check("wrap w0",  d, 32'hA0000002);
    rd(32'h4, d);       check("wrap w1",  d, 32'hA0000003);
    rd(32'h8, d);       check("wrap w2",  d, 32'h12);

    for (int k = 0; k < 8; k++) wbuf[k] = 32'hB000_0000 + 32'(k);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; sel = 4'hF;
    cti = CTI_INCR; dat = wbuf[0];
    wait_ack(lat);
    check("cyc-abort latency", 32'(lat), 32'(WS + 2));
    for (int k = 0; k < 2; k++) begin
      check("cyc-abort ack", {31'b0, ack}, 32'd1);
      tick;
      dat = wbuf[k+1];
      adr = adr + 32'd4;
    end
    cyc = 1'b0;
    repeat (2) begin
      tick;
      check("cyc-abort ack after drop", {31'b0, ack}, 32'd0);
    end
    bus_idle;
    model[4] = wbuf[0];
    model[5] = wbuf[1];
    for (int k = 0; k < 8; k++) begin
      rd(32'(4 * (4 + k)), d);
      check("cyc-abort word", d, (k < 2) ? 32'hB000_0000 + 32'(k) : 32'h14 + 32'(k));
    end

    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h20; sel = 4'hF; cti = CTI_INCR;
    wait_ack(lat);
    check("stb-abort latency", 32'(lat), 32'(WS + 2));
    for (int k = 0; k < 2; k++) begin
      check("stb-abort rdata", rdat, 32'h18 + 32'(k));
      tick;
    end
    stb = 1'b0;
    repeat (2) begin
      tick;
      check("stb-abort ack after drop", {31'b0, ack}, 32'd0);
    end
    stb = 1'b1; cti = CTI_CLASSIC; adr = 32'h30;
    wait_ack(lat);
    check("stb-abort restart latency", 32'(lat), 32'(WS + 2));
    check("stb-abort restart rdata", rdat, 32'h1C);
    tick;
    bus_idle;
    tick;

    for (int i = 0; i < 120; i++) begin
      n = ($urandom_range(0, 2) == 0) ? 1 : $urandom_range(2, 8);
      c = 3'($urandom_range(0, 7));
      if (c == CTI_INCR) c = CTI_CLASSIC;
      for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
      access(1'($urandom_range(0, 1)), $urandom, n, 4'($urandom_range(0, 15)), c, "random");
      repeat ($urandom_range(0, 2)) tick;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
